// File: rtl/pixel_framebuffer_pkg.sv
// Shared constants, address type and helpers for the 160x120 pixel framebuffer.
package fb_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int COLOUR_W = 3;

    localparam logic [2:0] COLOUR_WHITE = 3'b111;
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    localparam int FB_DEPTH  = 19200;
    localparam int FB_ADDR_W = 15;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    // Sweep FSM encoding
    localparam logic [0:0] FB_CLEAR = 1'b0;
    localparam logic [0:0] FB_IDLE  = 1'b1;

    // Linear address y*160 + x, built from shifts so no multiplier is inferred.
    function automatic fb_addr_t fb_addr(input logic [7:0] x, input logic [6:0] y);
        fb_addr_t yw;
        yw = fb_addr_t'(y);
        return (yw << 7) + (yw << 5) + fb_addr_t'(x);
    endfunction

endpackage

// File: rtl/pixel_framebuffer_if.sv
// Pixel-write, clear-control and scan-out read signals of the framebuffer.
interface pixel_framebuffer_if #(
    parameter int COLOUR_W = fb_pkg::COLOUR_W
) ();
    // Pixel writes from the sprite drawing blocks
    logic                plot;
    logic [7:0]          x_cord;
    logic [6:0]          y_cord;
    logic [COLOUR_W-1:0] colour_in;
    // Clear sweep control and status
    logic                clear_req;
    logic                busy;
    logic                clear_done;
    // Scan-out reads
    logic                rd_en;
    logic [7:0]          rd_x;
    logic [6:0]          rd_y;
    logic [COLOUR_W-1:0] rd_colour;
    logic                rd_valid;
    // Debug
    logic [7:0]          drop_count;

    modport master (
        output plot, x_cord, y_cord, colour_in, clear_req, rd_en, rd_x, rd_y,
        input  busy, clear_done, rd_colour, rd_valid, drop_count
    );

    modport slave (
        input  plot, x_cord, y_cord, colour_in, clear_req, rd_en, rd_x, rd_y,
        output busy, clear_done, rd_colour, rd_valid, drop_count
    );
endinterface

// File: rtl/pixel_framebuffer_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port,
// read-before-write on a same-address collision.
module fb_ram #(
    parameter int DEPTH  = fb_pkg::FB_DEPTH,
    parameter int WIDTH  = fb_pkg::COLOUR_W,
    parameter int ADDR_W = fb_pkg::FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port
    // NOTE: the storage array has no reset; the clear sweep initialises it, and
    // a reset here would turn the block RAM into thousands of flops.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; sees the pre-write contents on a collision
    // NOTE: non-blocking assignment is what gives read-before-write here --
    // every block samples mem before any update of this edge lands.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pixel_framebuffer.sv
// 160x120 framebuffer: accepts range-checked pixel writes, serves registered
// scan-out reads and clears itself with a one-address-per-cycle sweep.
module pixel_framebuffer #(
    parameter int                  SCREEN_W     = fb_pkg::SCREEN_W,
    parameter int                  SCREEN_H     = fb_pkg::SCREEN_H,
    parameter int                  COLOUR_W     = fb_pkg::COLOUR_W,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = fb_pkg::COLOUR_BLACK
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pixel_framebuffer_if.slave   bus
);
    import fb_pkg::*;

    localparam fb_addr_t SWEEP_LAST = fb_addr_t'(FB_DEPTH - 1);

    logic [0:0]          state_q, state_d;
    fb_addr_t            sweep_q, sweep_d;
    logic [7:0]          drop_q, drop_d;
    logic                rd_valid_q;
    logic                rd_oor_q;

    logic                wr_in_range, rd_in_range, wr_accept, sweep_last;
    logic                ram_we;
    fb_addr_t            ram_waddr, ram_raddr;
    logic [COLOUR_W-1:0] ram_wdata, ram_rdata;

    assign wr_in_range = (bus.x_cord < 8'(SCREEN_W)) && (bus.y_cord < 7'(SCREEN_H));
    assign rd_in_range = (bus.rd_x < 8'(SCREEN_W)) && (bus.rd_y < 7'(SCREEN_H));
    assign wr_accept   = bus.plot && (state_q == FB_IDLE) && wr_in_range;
    assign sweep_last  = (sweep_q == SWEEP_LAST);

    // The sweep owns the write port while clearing; pixel writes are dropped then.
    assign ram_we    = (state_q == FB_CLEAR) || wr_accept;
    assign ram_waddr = (state_q == FB_CLEAR) ? sweep_q : fb_addr(bus.x_cord, bus.y_cord);
    assign ram_wdata = (state_q == FB_CLEAR) ? CLEAR_COLOUR : bus.colour_in;
    // Out-of-range reads never touch the RAM, so aliased addresses cannot leak.
    assign ram_raddr = rd_in_range ? fb_addr(bus.rd_x, bus.rd_y) : '0;

    fb_ram #(
        .DEPTH  (FB_DEPTH),
        .WIDTH  (COLOUR_W),
        .ADDR_W (FB_ADDR_W)
    ) u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (bus.rd_en && rd_in_range),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Next-state logic for the sweep FSM and the saturating drop counter
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        drop_d  = drop_q;
        case (state_q)
            FB_CLEAR: begin
                if (sweep_last) begin
                    state_d = FB_IDLE;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + fb_addr_t'(1);
                end
            end
            default: begin
                if (bus.clear_req) begin
                    state_d = FB_CLEAR;
                    sweep_d = '0;
                end
            end
        endcase
        if (bus.plot && !wr_accept && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // FSM, sweep address and drop counter registers (reset restarts the sweep)
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= FB_CLEAR;
            sweep_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            drop_q  <= drop_d;
        end
    end

    // Read pipeline flags, aligned with the RAM's registered output
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_oor_q <= !rd_in_range;
            end
        end
    end

    assign bus.busy       = (state_q == FB_CLEAR);
    assign bus.clear_done = (state_q == FB_CLEAR) && sweep_last;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_oor_q ? CLEAR_COLOUR : ram_rdata;
    assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed self-checking bench for pixel_framebuffer.
module tb_pixel_framebuffer;
    import fb_pkg::*;

    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;
    int   cyc;

    pixel_framebuffer_if bus ();

    pixel_framebuffer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        bus.plot      = 1'b1;
        bus.x_cord    = x;
        bus.y_cord    = y;
        bus.colour_in = c;
        tick();
        bus.plot      = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] exp);
        bus.rd_en = 1'b1;
        bus.rd_x  = x;
        bus.rd_y  = y;
        tick();
        bus.rd_en = 1'b0;
        check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
        check(tag, 32'(bus.rd_colour), 32'(exp));
    endtask

    // Count cycles until clear_done, starting from sweep cycle number n.
    task automatic wait_done(input int n, output int n_out);
        n_out = n;
        while (!bus.clear_done && n_out < 25000) begin
            tick();
            n_out++;
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.plot      = 1'b0;
        bus.x_cord    = '0;
        bus.y_cord    = '0;
        bus.colour_in = '0;
        bus.clear_req = 1'b0;
        bus.rd_en     = 1'b0;
        bus.rd_x      = '0;
        bus.rd_y      = '0;
        tick();
        tick();

        // Reset values
        check("rst_busy",       32'(bus.busy),       32'd1);
        check("rst_clear_done", 32'(bus.clear_done), 32'd0);
        check("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
        check("rst_rd_colour",  32'(bus.rd_colour),  32'd0);
        check("rst_drop",       32'(bus.drop_count), 32'd0);

        // Reset clear: clear_done in cycle 19200, busy low in 19201
        reset_n = 1'b1;
        wait_done(1, cyc);
        check("init_sweep_len", 32'(cyc), 32'd19200);
        do_write(8'd1, 7'd1, COLOUR_WHITE);            // last sweep cycle: dropped
        check("busy_19201",       32'(bus.busy),       32'd0);
        check("clear_done_pulse", 32'(bus.clear_done), 32'd0);
        do_write(8'd2, 7'd1, COLOUR_WHITE);            // cycle 19201: accepted
        do_read("rd_0_0",     8'd0,   7'd0,   3'b000);
        do_read("rd_159_119", 8'd159, 7'd119, 3'b000);
        do_read("rd_80_60",   8'd80,  7'd60,  3'b000);
        do_read("rd_drop_1_1", 8'd1,  7'd1,   3'b000);
        do_read("rd_first_2_1", 8'd2, 7'd1,   3'b111);
        check("drop_first", 32'(bus.drop_count), 32'd1);

        // Basic write/read and out-of-range read
        do_write(8'd40, 7'd0, COLOUR_WHITE);
        do_read("rd_40_0", 8'd40, 7'd0, 3'b111);
        do_read("rd_41_0", 8'd41, 7'd0, 3'b000);
        tick();
        check("rd_valid_idle", 32'(bus.rd_valid), 32'd0);
        do_write(8'd0, 7'd6, COLOUR_WHITE);            // alias target of (160,5)
        do_read("rd_oor_160_5", 8'd160, 7'd5, 3'b000);
        do_read("rd_oor_0_120", 8'd0, 7'd120, 3'b000);

        // Out-of-range writes
        do_write(8'd160, 7'd10, COLOUR_WHITE);         // would alias (0,11)
        do_write(8'd3,   7'd120, COLOUR_WHITE);
        check("drop_oor", 32'(bus.drop_count), 32'd3);
        do_read("rd_alias_0_11", 8'd0, 7'd11, 3'b000);

        // Read/write collision returns old data
        bus.plot      = 1'b1;
        bus.x_cord    = 8'd10;
        bus.y_cord    = 7'd100;
        bus.colour_in = COLOUR_WHITE;
        bus.rd_en     = 1'b1;
        bus.rd_x      = 8'd10;
        bus.rd_y      = 7'd100;
        tick();
        bus.plot  = 1'b0;
        bus.rd_en = 1'b0;
        check("collide_old", 32'(bus.rd_colour), 32'd0);
        do_read("collide_new", 8'd10, 7'd100, 3'b111);

        // Clear during activity
        for (int y = 0; y < 60; y++) begin
            for (int x = 0; x < 40; x++) begin
                do_write(8'(x), 7'(y), COLOUR_WHITE);
            end
        end
        do_read("blk_pre_39_59", 8'd39, 7'd59, 3'b111);
        bus.clear_req = 1'b1;
        tick();                                        // now in sweep cycle 1
        bus.clear_req = 1'b0;
        check("clr_busy", 32'(bus.busy), 32'd1);
        cyc = 1;
        for (int i = 0; i < 5; i++) begin
            do_write(8'd3, 7'd3, COLOUR_WHITE);        // dropped during sweep
            cyc++;
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            cyc++;
        end
        bus.clear_req = 1'b1;                          // ignored mid-sweep
        tick();
        cyc++;
        bus.clear_req = 1'b0;
        wait_done(cyc, cyc);
        check("clr_sweep_len", 32'(cyc), 32'd19200);
        tick();
        check("clr_busy_low", 32'(bus.busy), 32'd0);
        check("drop_sweep", 32'(bus.drop_count), 32'd8);
        do_read("blk_0_0",   8'd0,  7'd0,  3'b000);
        do_read("blk_39_59", 8'd39, 7'd59, 3'b000);
        do_read("blk_20_30", 8'd20, 7'd30, 3'b000);
        do_read("blk_3_3",   8'd3,  7'd3,  3'b000);

        // Drop counter saturation
        for (int i = 0; i < 300; i++) begin
            do_write(8'd200, 7'd5, COLOUR_WHITE);
        end
        check("drop_sat", 32'(bus.drop_count), 32'd255);

        // Reset mid-sweep
        do_write(8'd159, 7'd119, COLOUR_WHITE);
        do_read("pre_rst_159_119", 8'd159, 7'd119, 3'b111);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            tick();                                    // ends at sweep address 5000
        end
        reset_n = 1'b0;
        tick();
        check("mid_rst_drop", 32'(bus.drop_count), 32'd0);
        check("mid_rst_busy", 32'(bus.busy),       32'd1);
        reset_n = 1'b1;
        wait_done(1, cyc);
        check("mid_rst_sweep_len", 32'(cyc), 32'd19200);
        tick();
        do_read("post_rst_159_119", 8'd159, 7'd119, 3'b000);
        check("post_rst_drop", 32'(bus.drop_count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_framebuffer.md
# pixel_framebuffer

On-chip 160×120 framebuffer with 3-bit colour. It is the receiving end of the pixel-write interface driven by the sprite drawing blocks (`plot`, `x_cord`, `y_cord`, colour). It stores each accepted pixel write and serves registered reads to the display scan-out logic. A sweep FSM clears the whole buffer after reset or on request, and dropped writes are counted for debug.

## Interface
- `SCREEN_W`, default 160: visible columns.
- `SCREEN_H`, default 120: visible rows.
- `COLOUR_W`, default 3: bits per pixel.
- `CLEAR_COLOUR`, default 3'b000: value written by a clear sweep (black).
- `clk`  in  1: clock clk.
- `reset_n`  in  1: reset reset_n, synchronous, active-low.
- `plot`  in  1: pixel write strobe; one write per cycle while high.
- `x_cord`  in  8: write column.
- `y_cord`  in  7: write row.
- `colour_in`  in  COLOUR_W: write data (3'b111 white, 3'b000 black).
- `clear_req`  in  1: single-cycle request to start a clear sweep.
- `busy`  out  1: high while a clear sweep is in progress.
- `clear_done`  out  1: one-cycle pulse on the last sweep write.
- `rd_en`  in  1: read request.
- `rd_x`  in  8: read column.
- `rd_y`  in  7: read row.
- `rd_colour`  out  COLOUR_W: read data.
- `rd_valid`  out  1: `rd_colour` is valid this cycle.
- `drop_count`  out  8: saturating count of rejected writes.

## Operation
- **States.**
  - CLEAR: sweep counter `addr_sweep` (15 bits) writes `CLEAR_COLOUR` to address 0..19199, one address per cycle.
  - IDLE: accepts pixel writes.
- **Transitions.**
  - Reset → CLEAR with `addr_sweep`=0.
  - CLEAR → IDLE when `addr_sweep`=19199 has been written; `clear_done` pulses in that cycle.
  - IDLE → CLEAR on `clear_req`=1, with `addr_sweep`=0.
  - `clear_req` during CLEAR is ignored; the sweep is not restarted.
- **Addressing.** Address = y·160 + x, computed as (y<<7)+(y<<5)+x, 15 bits wide; no multiplier.
- **Write acceptance.** A write is accepted iff `plot`=1, state=IDLE, `x_cord`<160 and `y_cord`<120.
- **Rejected writes.** Any other write with `plot`=1 is rejected: memory is unchanged and `drop_count` increments, saturating at 255.
- **Reads.** Reads are honoured in both states.
  - In-range read returns the stored value; during CLEAR this may be a stale value.
  - Out-of-range read (`rd_x`≥160 or `rd_y`≥120) returns `CLEAR_COLOUR` and still raises `rd_valid`.
- **Read/write collision.** Read and write to the same address in the same cycle: the read returns the old data (read-before-write).
- **Reset mid-sweep.** The sweep restarts from address 0; `drop_count` is cleared.

## Timing
- **Reset values:** `busy`=1 (CLEAR entered), `clear_done`=0, `rd_valid`=0, `rd_colour`=0, `drop_count`=0.
- **Write latency.** An accepted write updates memory at the same rising edge. A read issued on the next cycle sees the new value.
- **Read latency.** 1 cycle: `rd_en` sampled at edge N → `rd_colour`/`rd_valid` valid after edge N; `rd_valid`=0 when `rd_en` was 0.
- **Throughput.** One write and one read per cycle, sustained.
- **Sweep length.** A full clear takes 19200 cycles from entering CLEAR. `busy` falls the cycle after `clear_done`.
- **First write.** The first write accepted after reset is at cycle 19201 post-reset-release. Earlier writes are dropped and counted.

## Structure
- **Package `fb_pkg`:**
  - `SCREEN_W`, `SCREEN_H`, `COLOUR_W`;
  - colour constants `COLOUR_WHITE`=3'b111, `COLOUR_BLACK`=3'b000;
  - `FB_DEPTH`=19200 and address width 15;
  - state encoding `FB_CLEAR`/`FB_IDLE`.
- **Sub-module `fb_ram`:** simple dual-port synchronous RAM (1 write, 1 read, read-before-write), `FB_DEPTH`×`COLOUR_W`. The top level holds the FSM, address arithmetic, range checks and counters.

## Test plan
- **Reset clear.** Release reset, wait for `clear_done`. Read (0,0), (159,119), (80,60) → `rd_colour`=3'b000, `busy`=0 at cycle 19201.
- **Basic write/read.** Write (40,0)=3'b111, then read (40,0) next cycle → 3'b111 one cycle after `rd_en`. Read (41,0) → 3'b000.
- **Out-of-range write.** `plot` with x=160,y=5, then x=3,y=120 → memory unchanged, `drop_count`=2. 300 out-of-range writes → `drop_count`=255.
- **Collision.** (10,100) holds 3'b000; write 3'b111 and read (10,100) in the same cycle → read returns 3'b000. The next read returns 3'b111.
- **Clear during activity.** Fill a 40×60 block white, pulse `clear_req` → `busy`=1 next cycle. Writes during the sweep are dropped and counted; a second `clear_req` mid-sweep is ignored (`clear_done` after exactly 19200 cycles); afterwards the block reads 3'b000.
- **Reset mid-sweep.** Assert `reset_n`=0 at sweep address 5000 → after release, a full 19200-cycle sweep runs and `drop_count`=0.
